// File: rtl/tabuleiro_pkg.sv
// Shared colours, default board geometry, glyph size and the pixel category type
// used by the sudoku board renderer and its glyph lookup.
package tabuleiro_pkg;

  localparam int BLOCO_PAD    = 3;
  localparam int X_INICIO_PAD = 80;
  localparam int Y_INICIO_PAD = 0;
  localparam int ESCALA_PAD   = 4;
  localparam int CEL_PX_PAD   = 12;
  localparam int BLINK_PAD    = 30;

  // Seven-segment glyph box, centred inside the cell interior.
  localparam int GLIFO_W = 6;
  localparam int GLIFO_H = 9;

  localparam logic [11:0] COR_GROSSA = 12'h000;
  localparam logic [11:0] COR_FINA   = 12'h888;
  localparam logic [11:0] COR_FIXO   = 12'h000;
  localparam logic [11:0] COR_USER   = 12'h00F;
  localparam logic [11:0] COR_CURSOR = 12'hFF0;
  localparam logic [11:0] COR_FUNDO  = 12'h000;

  typedef enum logic [2:0] {
    CAT_FORA,
    CAT_GROSSA,
    CAT_FINA,
    CAT_GLIFO,
    CAT_CURSOR,
    CAT_VAZIO
  } cat_t;

  typedef struct packed {
    logic       grossa;
    logic       fina;
    logic [3:0] idx;
    logic [3:0] pos;
  } eixo_t;

  typedef struct packed {
    logic       dentro;
    logic       grossa;
    logic       fina;
    logic [3:0] lin;
    logic [3:0] col;
    logic [3:0] py;
    logic [3:0] px;
  } s1_t;

  function automatic logic [11:0] cor_de(input cat_t cat, input logic fixo_b);
    logic [11:0] cor;
    cor = COR_FUNDO;
    case (cat)
      CAT_GROSSA: cor = COR_GROSSA;
      CAT_FINA:   cor = COR_FINA;
      CAT_GLIFO:  cor = fixo_b ? COR_FIXO : COR_USER;
      CAT_CURSOR: cor = COR_CURSOR;
      default:    cor = COR_FUNDO;
    endcase
    return cor;
  endfunction

  function automatic logic ativo(input cat_t cat);
    return (cat == CAT_GROSSA) || (cat == CAT_FINA) ||
           (cat == CAT_GLIFO)  || (cat == CAT_CURSOR);
  endfunction

endpackage

// File: rtl/tabuleiro_grade_glifo_rom.sv
// Seven-segment digit glyphs 1..9 addressed by in-cell row/col 1..CEL_PX.
// Purely combinational; any other digit value yields no pixel.
module glifo_rom
  import tabuleiro_pkg::*;
#(
  parameter int CEL_PX = CEL_PX_PAD
) (
  input  logic [3:0] digito_i,
  input  logic [3:0] lin_i,
  input  logic [3:0] col_i,
  output logic       pix_o
);

  localparam logic [3:0] C0 = 4'((CEL_PX - GLIFO_W) / 2 + 1);
  localparam logic [3:0] C1 = 4'((CEL_PX - GLIFO_W) / 2 + GLIFO_W);
  localparam logic [3:0] R0 = 4'((CEL_PX - GLIFO_H) / 2 + 1);
  localparam logic [3:0] R1 = 4'((CEL_PX - GLIFO_H) / 2 + GLIFO_H);
  localparam logic [3:0] RM = 4'(((CEL_PX - GLIFO_H) / 2 + 1 + (CEL_PX - GLIFO_H) / 2 + GLIFO_H) / 2);

  logic [6:0] seg;  // {a,b,c,d,e,f,g}
  logic       faixa_h, sup, inf;

  always_comb begin
    seg = 7'b0000000;
    case (digito_i)
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  assign faixa_h = (col_i >= C0) && (col_i <= C1);
  assign sup     = (lin_i >= R0) && (lin_i <= RM);
  assign inf     = (lin_i >= RM) && (lin_i <= R1);

  assign pix_o = (seg[6] && lin_i == R0 && faixa_h) |
                 (seg[5] && col_i == C1 && sup)     |
                 (seg[4] && col_i == C1 && inf)     |
                 (seg[3] && lin_i == R1 && faixa_h) |
                 (seg[2] && col_i == C0 && inf)     |
                 (seg[1] && col_i == C0 && sup)     |
                 (seg[0] && lin_i == RM && faixa_h);

endmodule

// File: rtl/tabuleiro_grade.sv
// Sudoku board renderer: grid lines, digit glyphs and a blinking cursor cell.
// Two-stage pipeline, pixel in at cycle n gives colour at rising edge n+2.
module tabuleiro_grade
  import tabuleiro_pkg::*;
#(
  parameter int BLOCO        = BLOCO_PAD,
  parameter int X_INICIO     = X_INICIO_PAD,
  parameter int Y_INICIO     = Y_INICIO_PAD,
  parameter int ESCALA       = ESCALA_PAD,
  parameter int CEL_PX       = CEL_PX_PAD,
  parameter int BLINK_FRAMES = BLINK_PAD
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    refr_tick,
  input  logic [9:0]                              x,
  input  logic [9:0]                              y,
  input  logic [0:4*BLOCO*BLOCO*BLOCO*BLOCO-1]    sudoku,
  input  logic [BLOCO*BLOCO*BLOCO*BLOCO-1:0]      fixo,
  input  logic [3:0]                              cursor_lin,
  input  logic [3:0]                              cursor_col,
  input  logic                                    cursor_en,
  output logic [11:0]                             output_rgb,
  output logic                                    tabuleiro_on
);

  localparam int N    = BLOCO * BLOCO;
  localparam int SH   = $clog2(ESCALA);
  localparam int P    = CEL_PX + 1;
  localparam int B    = BLOCO * P + 1;
  localparam int LADO = BLOCO * B * ESCALA;
  localparam int FW   = $clog2(N * N);
  localparam int CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [11:0]   XI      = 12'(X_INICIO);
  localparam logic [11:0]   XF      = 12'(X_INICIO + LADO);
  localparam logic [11:0]   YI      = 12'(Y_INICIO);
  localparam logic [11:0]   YF      = 12'(Y_INICIO + LADO);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);

  // Splits one logical axis coordinate into line flags, cell index and in-cell position.
  function automatic eixo_t decod(input logic [11:0] l);
    int    li, r, sub, pos;
    eixo_t e;
    li       = int'(l);
    r        = li % B;
    sub      = r / P;
    pos      = r - sub * P;
    e.grossa = (r == 0) || (r == B - 1);
    e.fina   = !e.grossa && (pos == 0);
    e.idx    = 4'((li / B) * BLOCO + sub);
    e.pos    = 4'(pos);
    return e;
  endfunction

  // ---------------- Stage 1: geometry ----------------
  logic [11:0] xe, ye, dx, dy, lx, ly;
  logic        in_x, in_y;
  eixo_t       ex, ey;
  s1_t         s1_d, s1_q;

  assign xe   = {2'b00, x};
  assign ye   = {2'b00, y};
  assign dx   = xe - XI;
  assign dy   = ye - YI;
  assign lx   = dx >> SH;
  assign ly   = dy >> SH;
  assign in_x = (xe >= XI) && (xe < XF);
  assign in_y = (ye >= YI) && (ye < YF);
  assign ex   = decod(lx);
  assign ey   = decod(ly);

  always_comb begin
    s1_d        = '0;
    s1_d.dentro = in_x && in_y;
    s1_d.grossa = ex.grossa || ey.grossa;
    s1_d.fina   = ex.fina || ey.fina;
    s1_d.lin    = ey.idx;
    s1_d.col    = ex.idx;
    s1_d.py     = ey.pos;
    s1_d.px     = ex.pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  // ---------------- Frame-rate state: blink and cursor shadows ----------------
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    cur_lin_q, cur_lin_d, cur_col_q, cur_col_d;
  logic          cur_en_q, cur_en_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    cur_lin_d   = cur_lin_q;
    cur_col_d   = cur_col_q;
    cur_en_d    = cur_en_q;
    if (refr_tick) begin
      cur_lin_d = cursor_lin;
      cur_col_d = cursor_col;
      cur_en_d  = cursor_en;
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      cur_lin_q   <= '0;
      cur_col_q   <= '0;
      cur_en_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      cur_lin_q   <= cur_lin_d;
      cur_col_q   <= cur_col_d;
      cur_en_q    <= cur_en_d;
    end
  end

  // ---------------- Stage 2: cell content and colour ----------------
  logic [FW-1:0] cel;
  logic [FW+1:0] base;
  logic [3:0]    digito;
  logic          fixo_b, glifo_pix, glifo_hit, cursor_hit;
  cat_t          cat;

  assign cel  = FW'(int'(s1_q.lin) * N + int'(s1_q.col));
  assign base = {cel, 2'b00};

  always_comb begin
    digito = '0;
    fixo_b = 1'b0;
    if (cel < FW'(N * N)) begin
      digito = sudoku[base +: 4];
      fixo_b = fixo[cel];
    end
  end

  glifo_rom #(.CEL_PX(CEL_PX)) u_glifo (
    .digito_i (digito),
    .lin_i    (s1_q.py),
    .col_i    (s1_q.px),
    .pix_o    (glifo_pix)
  );

  assign glifo_hit  = glifo_pix && (digito >= 4'd1) && (digito <= 4'd9);
  assign cursor_hit = cur_en_q && blink_q &&
                      (cur_lin_q < 4'(N)) && (cur_col_q < 4'(N)) &&
                      (s1_q.lin == cur_lin_q) && (s1_q.col == cur_col_q);

  always_comb begin
    cat = CAT_VAZIO;
    if (!s1_q.dentro)    cat = CAT_FORA;
    else if (s1_q.grossa) cat = CAT_GROSSA;
    else if (s1_q.fina)   cat = CAT_FINA;
    else if (glifo_hit)   cat = CAT_GLIFO;
    else if (cursor_hit)  cat = CAT_CURSOR;
    else                  cat = CAT_VAZIO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_rgb   <= 12'h000;
      tabuleiro_on <= 1'b0;
    end else begin
      output_rgb   <= cor_de(cat, fixo_b);
      tabuleiro_on <= ativo(cat);
    end
  end

endmodule

// File: tb/tb_tabuleiro_grade.sv
// Directed-vector bench for tabuleiro_grade at default geometry (board x 80..559, y 0..479).
module tb_tabuleiro_grade;

  logic         clk;
  logic         rst;
  logic         refr_tick;
  logic [9:0]   x, y;
  logic [0:323] sudoku;
  logic [80:0]  fixo;
  logic [3:0]   cursor_lin, cursor_col;
  logic         cursor_en;
  logic [11:0]  output_rgb;
  logic         tabuleiro_on;

  int nvec = 0;
  int nbad = 0;

  tabuleiro_grade dut (
    .clk          (clk),
    .rst          (rst),
    .refr_tick    (refr_tick),
    .x            (x),
    .y            (y),
    .sudoku       (sudoku),
    .fixo         (fixo),
    .cursor_lin   (cursor_lin),
    .cursor_col   (cursor_col),
    .cursor_en    (cursor_en),
    .output_rgb   (output_rgb),
    .tabuleiro_on (tabuleiro_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic put_pix(input int px, input int py);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      refr_tick = 1'b1;
      @(negedge clk);
      refr_tick = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    nvec++;
    if (output_rgb !== 12'h000 || tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL reset_state: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lines;
    put_pix(79, 0);
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL pre_latency_off: on=%b, want 0", tabuleiro_on);
    end
    @(negedge clk);
    x = 10'd80;
    y = 10'd0;
    @(posedge clk);
    #1;
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL latency_one_edge: on=%b, want 0 after one edge", tabuleiro_on);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL thick_corner: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(132, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h888) begin
      nbad++;
      $display("FAIL thin_vertical: on=%b rgb=%h, want on=1 rgb=888", tabuleiro_on, output_rgb);
    end
    put_pix(84, 52);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h888) begin
      nbad++;
      $display("FAIL thin_horizontal: on=%b rgb=%h, want on=1 rgb=888", tabuleiro_on, output_rgb);
    end
    put_pix(240, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL thick_block_edge: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL empty_interior: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
  endtask

  task automatic test_bounds;
    put_pix(559, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL last_column_thick: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(560, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL right_outside: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(79, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL left_outside: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(100, 480);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL below_outside: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
  endtask

  task automatic test_glyph;
    // (100,8) -> cell (0,0), in-cell row 2 col 5: top segment of the glyph
    sudoku[0 +: 4] = 4'd5;
    fixo[0] = 1'b0;
    put_pix(100, 8);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h00F) begin
      nbad++;
      $display("FAIL glyph_user: on=%b rgb=%h, want on=1 rgb=00F", tabuleiro_on, output_rgb);
    end
    fixo[0] = 1'b1;
    put_pix(100, 8);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL glyph_fixed: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    sudoku[0 +: 4] = 4'd12;
    put_pix(100, 8);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL glyph_invalid_digit: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    // (204,60) -> cell (1,2), in-cell row 2 col 5; cell index 11, bits 44..47
    sudoku[44 +: 4] = 4'd8;
    fixo[11] = 1'b0;
    put_pix(204, 60);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h00F) begin
      nbad++;
      $display("FAIL glyph_cell_1_2: on=%b rgb=%h, want on=1 rgb=00F", tabuleiro_on, output_rgb);
    end
    fixo[11] = 1'b1;
    put_pix(204, 60);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL glyph_cell_1_2_fixed: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    sudoku[44 +: 4] = 4'd0;
    put_pix(204, 60);
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL glyph_zero_digit: on=%b, want 0", tabuleiro_on);
    end
  endtask

  task automatic test_cursor;
    cursor_lin = 4'd0;
    cursor_col = 4'd0;
    cursor_en  = 1'b1;
    ticks(29);
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL cursor_before_wrap: on=%b rgb=%h, want on=0", tabuleiro_on, output_rgb);
    end
    ticks(1);
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'hFF0) begin
      nbad++;
      $display("FAIL cursor_on: on=%b rgb=%h, want on=1 rgb=FF0", tabuleiro_on, output_rgb);
    end
    cursor_lin = 4'd1;
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'hFF0) begin
      nbad++;
      $display("FAIL cursor_shadow_hold: on=%b rgb=%h, want on=1 rgb=FF0", tabuleiro_on, output_rgb);
    end
    cursor_lin = 4'd0;
    ticks(30);
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL cursor_off_phase: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
  endtask

  task automatic test_reset_mid;
    cursor_col = 4'd8;
    ticks(30);
    // (512,4) -> cell (0,8), interior outside the glyph box
    put_pix(512, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'hFF0) begin
      nbad++;
      $display("FAIL cursor_col8: on=%b rgb=%h, want on=1 rgb=FF0", tabuleiro_on, output_rgb);
    end
    ticks(20);
    put_pix(512, 4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL async_reset_clear: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    @(negedge clk);
    rst = 1'b0;
    x = 10'd80;
    y = 10'd0;
    @(posedge clk);
    #1;
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL post_reset_edge1: on=%b, want 0", tabuleiro_on);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL post_reset_edge2: on=%b rgb=%h, want on=1 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(512, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL shadow_cleared: on=%b rgb=%h, want on=0", tabuleiro_on, output_rgb);
    end
    ticks(29);
    put_pix(512, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0) begin
      nbad++;
      $display("FAIL blink_restart_29: on=%b rgb=%h, want on=0", tabuleiro_on, output_rgb);
    end
    ticks(1);
    put_pix(512, 4);
    nvec++;
    if (tabuleiro_on !== 1'b1 || output_rgb !== 12'hFF0) begin
      nbad++;
      $display("FAIL blink_restart_30: on=%b rgb=%h, want on=1 rgb=FF0", tabuleiro_on, output_rgb);
    end
    cursor_col = 4'd9;
    ticks(1);
    put_pix(512, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL cursor_col9_last: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
    put_pix(84, 4);
    nvec++;
    if (tabuleiro_on !== 1'b0 || output_rgb !== 12'h000) begin
      nbad++;
      $display("FAIL cursor_col9_first: on=%b rgb=%h, want on=0 rgb=000", tabuleiro_on, output_rgb);
    end
  endtask

  initial begin
    rst        = 1'b1;
    refr_tick  = 1'b0;
    x          = 10'd0;
    y          = 10'd0;
    sudoku     = '0;
    fixo       = '0;
    cursor_lin = 4'd0;
    cursor_col = 4'd0;
    cursor_en  = 1'b0;

    test_reset();
    test_lines();
    test_bounds();
    test_glyph();
    test_cursor();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
